vga_timing_gen: RTL and testbench

//  Generates 640x480@60Hz VGA raster timing from the 100 MHz system clock.

---
 rtl/vga_timing_gen_if.sv | 22 ++
 rtl/vga_timing_gen.sv | 137 +++++++++++++
 tb/tb_vga_timing_gen.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - raster timing bundle from vga_timing_gen to the display colour stages
interface vga_timing_gen_if;
  logic       pix_en;
  logic [9:0] x_cnt;
  logic [9:0] y_cnt;
  logic       hsync;
  logic       vsync;
  logic       valid;
  logic       line_start;
  logic       frame_start;
  logic [7:0] frame_cnt;

  modport master (
    output pix_en, x_cnt, y_cnt, hsync, vsync, valid,
           line_start, frame_start, frame_cnt
  );

  modport slave (
    input  pix_en, x_cnt, y_cnt, hsync, vsync, valid,
           line_start, frame_start, frame_cnt
  );
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - 640x480@60Hz VGA raster timing (pixel divider, x/y counters, syncs, strobes)
// Optional VGA_SYNC_DELAY_EN: hsync/vsync/valid delayed by one pixel period.
module vga_timing_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int SYNC_POL  = 0
) (
  input  logic             clk,
  input  logic             rst,
  vga_timing_gen_if.master tim_o
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] X_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] Y_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic       SYNC_ON  = (SYNC_POL != 0);

  logic [DIV_W-1:0] div_q, div_d;
  logic             pix_en_q, pix_en_d;
  logic [9:0]       x_q, x_d;
  logic [9:0]       y_q, y_d;
  logic [7:0]       fcnt_q, fcnt_d;
  logic             line_start_q, line_start_d;
  logic             frame_start_q, frame_start_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             valid_q, valid_d;

  always_comb begin
    div_d         = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    pix_en_d      = (div_d == DIV_LAST);
    x_d           = x_q;
    y_d           = y_q;
    fcnt_d        = fcnt_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;

    if (pix_en_q) begin
      if (x_q == X_LAST) begin
        x_d          = '0;
        line_start_d = 1'b1;
        if (y_q == Y_LAST) begin
          y_d           = '0;
          frame_start_d = 1'b1;
          fcnt_d        = fcnt_q + 8'd1;
        end else begin
          y_d = y_q + 10'd1;
        end
      end else begin
        x_d = x_q + 10'd1;
      end
    end

    // Decoded from the next-state counters so the registered syncs line up with x/y.
    hsync_d = ((x_d >= HS_START) && (x_d < HS_END)) ? SYNC_ON : ~SYNC_ON;
    vsync_d = ((y_d >= VS_START) && (y_d < VS_END)) ? SYNC_ON : ~SYNC_ON;
    valid_d = (x_d < X_VIS) && (y_d < Y_VIS);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q         <= '0;
      pix_en_q      <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      fcnt_q        <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      hsync_q       <= ~SYNC_ON;
      vsync_q       <= ~SYNC_ON;
      valid_q       <= 1'b0;
    end else begin
      div_q         <= div_d;
      pix_en_q      <= pix_en_d;
      x_q           <= x_d;
      y_q           <= y_d;
      fcnt_q        <= fcnt_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      valid_q       <= valid_d;
    end
  end

`ifdef VGA_SYNC_DELAY_EN
  logic hsync_dly_q;
  logic vsync_dly_q;
  logic valid_dly_q;

  // Captured on the pixel edge, so each output describes the previous pixel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hsync_dly_q <= ~SYNC_ON;
      vsync_dly_q <= ~SYNC_ON;
      valid_dly_q <= 1'b0;
    end else if (pix_en_q) begin
      hsync_dly_q <= hsync_q;
      vsync_dly_q <= vsync_q;
      valid_dly_q <= valid_q;
    end
  end

  assign tim_o.hsync = hsync_dly_q;
  assign tim_o.vsync = vsync_dly_q;
  assign tim_o.valid = valid_dly_q;
`else
  assign tim_o.hsync = hsync_q;
  assign tim_o.vsync = vsync_q;
  assign tim_o.valid = valid_q;
`endif

  assign tim_o.pix_en      = pix_en_q;
  assign tim_o.x_cnt       = x_q;
  assign tim_o.y_cnt       = y_q;
  assign tim_o.line_start  = line_start_q;
  assign tim_o.frame_start = frame_start_q;
  assign tim_o.frame_cnt   = fcnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - randomized bench for vga_timing_gen against an arithmetic raster model
// Small raster geometry keeps 256+ frames affordable.
module tb_vga_timing_gen;

  localparam int CD  = 3;
  localparam int HV  = 6, HF = 1, HS = 2, HB = 1;
  localparam int VV  = 4, VF = 1, VS = 1, VB = 1;
  localparam int SP  = 0;
  localparam int HT  = HV + HF + HS + HB;
  localparam int VT  = VV + VF + VS + VB;
  localparam int PIX_PER_FRAME = HT * VT;

  logic clk;
  logic rst;

  vga_timing_gen_if vif ();

  vga_timing_gen #(
    .CLK_DIV(CD), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_POL(SP)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .tim_o (vif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int t     = 0;
  int prev_fcnt = 0;
  int saw_wrap  = 0;

  task automatic chk(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (clk %0d since release)", tag, got, exp, t);
    end
  endtask

  // Sync/valid levels for a given absolute pixel index since reset release.
  task automatic pixel_levels(input int p, output int hs, output int vs, output int vd);
    int x, y;
    x  = p % HT;
    y  = (p / HT) % VT;
    hs = (x >= HV + HF && x < HV + HF + HS) ? SP : 1 - SP;
    vs = (y >= VV + VF && y < VV + VF + VS) ? SP : 1 - SP;
    vd = (x < HV && y < VV) ? 1 : 0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_pix_en"}, vif.pix_en, 0);
    chk({tag, "_x"}, vif.x_cnt, 0);
    chk({tag, "_y"}, vif.y_cnt, 0);
    chk({tag, "_hsync"}, vif.hsync, 1 - SP);
    chk({tag, "_vsync"}, vif.vsync, 1 - SP);
    chk({tag, "_valid"}, vif.valid, 0);
    chk({tag, "_line_start"}, vif.line_start, 0);
    chk({tag, "_frame_start"}, vif.frame_start, 0);
    chk({tag, "_frame_cnt"}, vif.frame_cnt, 0);
  endtask

  // Expected outputs after t clock edges since release (t >= 1).
  task automatic check_cycle();
    int p, x, y, hs, vs, vd, strobe;
    p      = t / CD;
    x      = p % HT;
    y      = (p / HT) % VT;
    strobe = (t % CD == 0) ? 1 : 0;
    chk("pix_en", vif.pix_en, (t % CD == CD - 1) ? 1 : 0);
    chk("x_cnt", vif.x_cnt, x);
    chk("y_cnt", vif.y_cnt, y);
    chk("frame_cnt", vif.frame_cnt, (p / PIX_PER_FRAME) % 256);
    chk("line_start", vif.line_start, (strobe && x == 0) ? 1 : 0);
    chk("frame_start", vif.frame_start, (strobe && x == 0 && y == 0) ? 1 : 0);
`ifdef VGA_SYNC_DELAY_EN
    if (p == 0) begin
      hs = 1 - SP; vs = 1 - SP; vd = 0;
    end else begin
      pixel_levels(p - 1, hs, vs, vd);
    end
`else
    pixel_levels(p, hs, vs, vd);
`endif
    chk("hsync", vif.hsync, hs);
    chk("vsync", vif.vsync, vs);
    chk("valid", vif.valid, vd);
    if (prev_fcnt == 255 && int'(vif.frame_cnt) == 0) saw_wrap = 1;
    prev_fcnt = int'(vif.frame_cnt);
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      t++;
      @(negedge clk);
      check_cycle();
    end
  endtask

  task automatic async_reset(input int off, input string tag);
    @(posedge clk);
    #(off);
    rst = 1'b0;
    #1;
    check_reset_state({tag, "_async"});
    repeat ($urandom_range(1, 4)) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    t = 0;
    prev_fcnt = 0;
    check_reset_state({tag, "_release"});
  endtask

  initial begin
    int guard;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_reset_state("hold");
    rst = 1'b1;
    t = 0;
    check_reset_state("release");
    run(3 * HT * CD);

    for (int seg = 0; seg < 6; seg++) begin
      run($urandom_range(20, 2000));
      async_reset($urandom_range(1, 8), "rand");
    end

    // Reset landing while hsync is asserted must drop it immediately.
    run($urandom_range(HT * CD, 4 * PIX_PER_FRAME * CD));
    guard = 0;
    while (!((t / CD) % HT >= HV + HF && (t / CD) % HT < HV + HF + HS) && guard < 10000) begin
      run(1);
      guard++;
    end
    chk("hsync_window_reached", (guard < 10000) ? 1 : 0, 1);
    chk("hsync_active_before_reset", vif.hsync, SP);
    async_reset($urandom_range(1, 8), "in_hsync");

    saw_wrap = 0;
    run(257 * PIX_PER_FRAME * CD);
    chk("frame_cnt_wrap_255_to_0", saw_wrap, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
